// File: rtl/mbank_pkg.sv
// mbank_pkg: shared types and default geometry for the memory bank.
//   port_e        - write-port identifier used for the round-robin pointer and grant
//   MBANK_DEPTH   - default number of bank rows
//   MBANK_WIDTH   - default data width per row
package mbank_pkg;

    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

    localparam int unsigned MBANK_DEPTH = 16;
    localparam int unsigned MBANK_WIDTH = 8;

endpackage

// File: rtl/mbank_addr_dec.sv
// mbank_addr_dec: combinational row-address decoder for the memory bank.
// Ports:
//   addr      in   ADDR_W  row address
//   row_oh_c  out  DEPTH   one-hot row select (all-zero when out of range)
//   oor_c     out  1       address is >= DEPTH
module mbank_addr_dec
    import mbank_pkg::*;
#(
    parameter int unsigned DEPTH  = MBANK_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [DEPTH-1:0]  row_oh_c,
    output logic              oor_c
);

    // One-hot decode; an out-of-range address matches no row.
    always_comb begin
        row_oh_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (addr == ADDR_W'(i)) begin
                row_oh_c[i] = 1'b1;
            end
        end
    end

    // Zero-extend so non-power-of-two depths compare correctly.
    assign oor_c = ({1'b0, addr} >= (ADDR_W + 1)'(DEPTH));

endmodule

// File: rtl/mbank_wr_arb.sv
// mbank_wr_arb: round-robin write arbiter and registered CE generator for the bank.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   a_valid/a_addr/a_data  port A write request;  a_ready: A accepted this cycle
//   b_valid/b_addr/b_data  port B write request;  b_ready: B accepted this cycle
//   ce                     registered one-hot row enable (zero when idle)
//   wdata                  registered write data, valid when ce != 0
//   oor                    registered pulse: accepted address was >= DEPTH
//   conflict_cnt           (only with MBANK_WR_ARB_CNT_EN) saturating count of
//                          cycles with both valids high
// Optional feature macro: MBANK_WR_ARB_CNT_EN
module mbank_wr_arb
    import mbank_pkg::*;
#(
    parameter int unsigned DEPTH  = MBANK_DEPTH,
    parameter int unsigned WIDTH  = MBANK_WIDTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [WIDTH-1:0]  a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [WIDTH-1:0]  b_data,
    output logic              b_ready,
    output logic [DEPTH-1:0]  ce,
    output logic [WIDTH-1:0]  wdata,
    output logic              oor
`ifdef MBANK_WR_ARB_CNT_EN
    ,
    output logic [15:0]       conflict_cnt
`endif
);

    port_e             ptr_q, ptr_d;
    logic [DEPTH-1:0]  ce_q, ce_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic              oor_q, oor_d;

    logic              xfer_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [WIDTH-1:0]  sel_data_c;
    logic [DEPTH-1:0]  dec_oh_c;
    logic              dec_oor_c;

    // Grant: a lone requester wins, contention goes to the pointer; reset blocks both.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst) begin
            if (a_valid && (!b_valid || ptr_q == PORT_A)) begin
                a_ready = 1'b1;
            end else if (b_valid) begin
                b_ready = 1'b1;
            end
        end
    end

    assign xfer_c     = a_ready | b_ready;
    assign sel_addr_c = a_ready ? a_addr : b_addr;
    assign sel_data_c = a_ready ? a_data : b_data;

    mbank_addr_dec #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_addr_dec (
        .addr     (sel_addr_c),
        .row_oh_c (dec_oh_c),
        .oor_c    (dec_oor_c)
    );

    // Next state: pointer flips to the loser, output register loads every cycle.
    always_comb begin
        ptr_d   = ptr_q;
        ce_d    = '0;
        wdata_d = wdata_q;
        oor_d   = 1'b0;
        if (a_ready) begin
            ptr_d = PORT_B;
        end else if (b_ready) begin
            ptr_d = PORT_A;
        end
        if (xfer_c) begin
            if (dec_oor_c) begin
                oor_d = 1'b1;
            end else begin
                ce_d    = dec_oh_c;
                wdata_d = sel_data_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= PORT_A;
            ce_q    <= '0;
            wdata_q <= '0;
            oor_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            ce_q    <= ce_d;
            wdata_q <= wdata_d;
            oor_q   <= oor_d;
        end
    end

    assign ce    = ce_q;
    assign wdata = wdata_q;
    assign oor   = oor_q;

`ifdef MBANK_WR_ARB_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating contention counter.
    always_comb begin
        cnt_d = cnt_q;
        if (a_valid && b_valid && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mbank_wr_arb.sv
module tb_mbank_wr_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, b_valid;
    logic [3:0] a_addr, b_addr;
    logic [7:0] a_data, b_data;

    logic        a_ready16, b_ready16, oor16;
    logic [15:0] ce16;
    logic [7:0]  wd16;
    logic        a_ready12, b_ready12, oor12;
    logic [11:0] ce12;
    logic [7:0]  wd12;
`ifdef MBANK_WR_ARB_CNT_EN
    logic [15:0] cnt16, cnt12;
`endif

    always #5 clk = ~clk;

    mbank_wr_arb #(.DEPTH(16), .WIDTH(8)) dut16 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready16),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready16),
        .ce(ce16), .wdata(wd16), .oor(oor16)
`ifdef MBANK_WR_ARB_CNT_EN
        , .conflict_cnt(cnt16)
`endif
    );

    mbank_wr_arb #(.DEPTH(12), .WIDTH(8)) dut12 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready12),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready12),
        .ce(ce12), .wdata(wd12), .oor(oor12)
`ifdef MBANK_WR_ARB_CNT_EN
        , .conflict_cnt(cnt12)
`endif
    );

    int chk = 0;
    int err = 0;

    // Reference model state
    bit          m_ptr;          // 0 = A has priority, 1 = B
    logic        e_ar, e_br;
    logic [15:0] e_ce16;
    logic [11:0] e_ce12;
    logic [7:0]  e_wd16, e_wd12;
    logic        e_oor16, e_oor12;
    logic [3:0]  e_waddr;
    int          e_cnt;
    logic [7:0]  e_mem [16];
    logic [7:0]  o_mem [16];

    // Bank rows as seen from the DUT outputs
    always @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (ce16[i] === 1'b1) o_mem[i] <= wd16;
        end
    end

    task automatic model_reset;
        m_ptr = 1'b0;
        e_ar = 1'b0; e_br = 1'b0;
        e_ce16 = '0; e_ce12 = '0;
        e_wd16 = '0; e_wd12 = '0;
        e_oor16 = 1'b0; e_oor12 = 1'b0;
        e_cnt = 0;
    endtask

    task automatic drive(input logic av, input logic [3:0] aa, input logic [7:0] ad,
                         input logic bv, input logic [3:0] ba, input logic [7:0] bd);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        #1;
        if (rst) begin
            e_ar = 1'b0; e_br = 1'b0;
        end else begin
            e_ar = av && (!bv || m_ptr == 1'b0);
            e_br = bv && !e_ar;
        end
    endtask

    task automatic drive_idle;
        drive(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0);
    endtask

    task automatic tick;
        logic [3:0] ad;
        logic [7:0] dt;
        logic       xf;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (a_valid && b_valid && e_cnt < 65535) e_cnt++;
            if (e_ce16 != 0) e_mem[e_waddr] = e_wd16;
            xf = e_ar || e_br;
            ad = e_ar ? a_addr : b_addr;
            dt = e_ar ? a_data : b_data;
            if (e_ar) m_ptr = 1'b1;
            else if (e_br) m_ptr = 1'b0;
            e_ce16 = '0; e_oor16 = 1'b0;
            e_ce12 = '0; e_oor12 = 1'b0;
            if (xf) begin
                if (ad < 16) begin
                    e_ce16 = 16'd1 << ad; e_wd16 = dt; e_waddr = ad;
                end else e_oor16 = 1'b1;
                if (ad < 12) begin
                    e_ce12 = 12'd1 << ad; e_wd12 = dt;
                end else e_oor12 = 1'b1;
            end
        end
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        model_reset();
        drive_idle();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        model_reset();
        drive(1'b1, 4'd0, 8'h5A, 1'b1, 4'd7, 8'h3C);
        tick();
        chk++; if (a_ready16 !== 1'b0 || b_ready16 !== 1'b0) begin
            err++; $display("FAIL rst_ready got a=%b b=%b exp 0 0", a_ready16, b_ready16);
        end
        chk++; if (ce16 !== 16'h0 || wd16 !== 8'h0 || oor16 !== 1'b0) begin
            err++; $display("FAIL rst_out got ce=%h wd=%h oor=%b exp 0 0 0", ce16, wd16, oor16);
        end
`ifdef MBANK_WR_ARB_CNT_EN
        chk++; if (cnt16 !== 16'd0) begin
            err++; $display("FAIL rst_cnt got %0d exp 0", cnt16);
        end
`endif
        rst = 1'b0;
        drive(1'b1, 4'd0, 8'h5A, 1'b1, 4'd7, 8'h3C);
        chk++; if (a_ready16 !== 1'b1 || b_ready16 !== 1'b0) begin
            err++; $display("FAIL rst_first_grant got a=%b b=%b exp 1 0", a_ready16, b_ready16);
        end
        tick();
        chk++; if (ce16 !== 16'h0001 || wd16 !== 8'h5A) begin
            err++; $display("FAIL rst_first_ce got ce=%h wd=%h exp 0001 5a", ce16, wd16);
        end
        drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd7, 8'h3C);
        chk++; if (b_ready16 !== 1'b1) begin
            err++; $display("FAIL rst_second_grant got b=%b exp 1", b_ready16);
        end
        tick();
        chk++; if (ce16 !== 16'h0080 || wd16 !== 8'h3C) begin
            err++; $display("FAIL rst_second_ce got ce=%h wd=%h exp 0080 3c", ce16, wd16);
        end
        drive_idle();
        tick();
    endtask

    task automatic test_single_a;
        drive(1'b1, 4'd5, 8'hA5, 1'b0, 4'd0, 8'h00);
        chk++; if (a_ready16 !== 1'b1 || b_ready16 !== 1'b0) begin
            err++; $display("FAIL single_ready got a=%b b=%b exp 1 0", a_ready16, b_ready16);
        end
        tick();
        chk++; if (ce16 !== 16'h0020 || wd16 !== 8'hA5) begin
            err++; $display("FAIL single_ce got ce=%h wd=%h exp 0020 a5", ce16, wd16);
        end
        drive_idle();
        tick();
        chk++; if (ce16 !== 16'h0000 || wd16 !== 8'hA5) begin
            err++; $display("FAIL single_hold got ce=%h wd=%h exp 0000 a5", ce16, wd16);
        end
    endtask

    task automatic test_same_addr;
        // B-only write leaves the pointer at A
        drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd9, 8'h99);
        chk++; if (b_ready16 !== 1'b1) begin
            err++; $display("FAIL same_bonly got b=%b exp 1", b_ready16);
        end
        tick();
        drive(1'b1, 4'd3, 8'h11, 1'b1, 4'd3, 8'h22);
        chk++; if (a_ready16 !== 1'b1 || b_ready16 !== 1'b0) begin
            err++; $display("FAIL same_grant1 got a=%b b=%b exp 1 0", a_ready16, b_ready16);
        end
        tick();
        chk++; if (ce16 !== 16'h0008 || wd16 !== 8'h11) begin
            err++; $display("FAIL same_ce1 got ce=%h wd=%h exp 0008 11", ce16, wd16);
        end
        drive(1'b0, 4'd3, 8'h11, 1'b1, 4'd3, 8'h22);
        chk++; if (a_ready16 !== 1'b0 || b_ready16 !== 1'b1) begin
            err++; $display("FAIL same_grant2 got a=%b b=%b exp 0 1", a_ready16, b_ready16);
        end
        tick();
        chk++; if (ce16 !== 16'h0008 || wd16 !== 8'h22) begin
            err++; $display("FAIL same_ce2 got ce=%h wd=%h exp 0008 22", ce16, wd16);
        end
        drive_idle();
        tick();
        drive_idle();
        tick();
        chk++; if (o_mem[3] !== 8'h22) begin
            err++; $display("FAIL same_row got %h exp 22", o_mem[3]);
        end
    endtask

    task automatic test_contention;
        logic exp_a;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 4'(i), 8'(i), 1'b1, 4'(i + 8), 8'(i + 16));
            exp_a = (i % 2 == 0);
            chk++; if (a_ready16 !== exp_a || b_ready16 !== !exp_a) begin
                err++; $display("FAIL cont_ready cyc=%0d got a=%b b=%b exp %b %b",
                                i, a_ready16, b_ready16, exp_a, !exp_a);
            end
            tick();
            chk++; if ($countones(ce16) > 1 || ce16 !== e_ce16) begin
                err++; $display("FAIL cont_ce cyc=%0d got %h exp %h", i, ce16, e_ce16);
            end
        end
`ifdef MBANK_WR_ARB_CNT_EN
        chk++; if (cnt16 !== 16'd6 || cnt12 !== 16'd6) begin
            err++; $display("FAIL cont_cnt got %0d/%0d exp 6", cnt16, cnt12);
        end
`endif
        drive_idle();
        tick();
    endtask

    task automatic test_oor;
        logic [7:0] wd_before;
        wd_before = e_wd12;
        drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd13, 8'h77);
        chk++; if (b_ready12 !== 1'b1 || a_ready12 !== 1'b0) begin
            err++; $display("FAIL oor_ready got a=%b b=%b exp 0 1", a_ready12, b_ready12);
        end
        tick();
        chk++; if (oor12 !== 1'b1 || ce12 !== 12'h000 || wd12 !== wd_before) begin
            err++; $display("FAIL oor_out got oor=%b ce=%h wd=%h exp 1 000 %h",
                            oor12, ce12, wd12, wd_before);
        end
        chk++; if (oor16 !== 1'b0 || ce16 !== 16'h2000 || wd16 !== 8'h77) begin
            err++; $display("FAIL oor_inrange16 got oor=%b ce=%h wd=%h exp 0 2000 77",
                            oor16, ce16, wd16);
        end
        drive_idle();
        tick();
        chk++; if (oor12 !== 1'b0) begin
            err++; $display("FAIL oor_pulse got %b exp 0", oor12);
        end
    endtask

    task automatic test_reset_mid;
        drive(1'b1, 4'd2, 8'h44, 1'b0, 4'd0, 8'h00);
        tick();
        chk++; if (ce16 !== 16'h0004) begin
            err++; $display("FAIL mid_pre got ce=%h exp 0004", ce16);
        end
        drive_idle();
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk++; if (ce16 !== 16'h0000 || wd16 !== 8'h00) begin
            err++; $display("FAIL mid_async got ce=%h wd=%h exp 0000 00", ce16, wd16);
        end
        tick();
        rst = 1'b0;
        drive(1'b1, 4'd6, 8'h66, 1'b1, 4'd1, 8'h61);
        chk++; if (a_ready16 !== 1'b1 || b_ready16 !== 1'b0) begin
            err++; $display("FAIL mid_ptr got a=%b b=%b exp 1 0", a_ready16, b_ready16);
        end
        tick();
        chk++; if (ce16 !== 16'h0040 || wd16 !== 8'h66) begin
            err++; $display("FAIL mid_ce got ce=%h wd=%h exp 0040 66", ce16, wd16);
        end
        drive_idle();
        tick();
    endtask

    task automatic test_random;
        logic       ap, bp;
        logic [3:0] aa, ba;
        logic [7:0] ad, bd;
        ap = 1'b0; bp = 1'b0;
        aa = '0; ba = '0; ad = '0; bd = '0;
        for (int c = 0; c < 400; c++) begin
            if (!ap && $urandom_range(0, 9) < 6) begin
                ap = 1'b1; aa = 4'($urandom_range(0, 15)); ad = 8'($urandom);
            end
            if (!bp && $urandom_range(0, 9) < 6) begin
                bp = 1'b1; ba = 4'($urandom_range(0, 15)); bd = 8'($urandom);
            end
            drive(ap, aa, ad, bp, ba, bd);
            chk++; if (a_ready16 !== e_ar || b_ready16 !== e_br ||
                       a_ready12 !== e_ar || b_ready12 !== e_br) begin
                err++; $display("FAIL rnd_ready cyc=%0d got %b%b/%b%b exp %b%b",
                                c, a_ready16, b_ready16, a_ready12, b_ready12, e_ar, e_br);
            end
            if (e_ar) ap = 1'b0;
            if (e_br) bp = 1'b0;
            tick();
            chk++; if (ce16 !== e_ce16 || wd16 !== e_wd16 || oor16 !== e_oor16 ||
                       $countones(ce16) > 1) begin
                err++; $display("FAIL rnd_out16 cyc=%0d got %h %h %b exp %h %h %b",
                                c, ce16, wd16, oor16, e_ce16, e_wd16, e_oor16);
            end
            chk++; if (ce12 !== e_ce12 || wd12 !== e_wd12 || oor12 !== e_oor12 ||
                       $countones(ce12) > 1) begin
                err++; $display("FAIL rnd_out12 cyc=%0d got %h %h %b exp %h %h %b",
                                c, ce12, wd12, oor12, e_ce12, e_wd12, e_oor12);
            end
        end
`ifdef MBANK_WR_ARB_CNT_EN
        chk++; if (cnt16 !== 16'(e_cnt) || cnt12 !== 16'(e_cnt)) begin
            err++; $display("FAIL rnd_cnt got %0d/%0d exp %0d", cnt16, cnt12, e_cnt);
        end
`endif
        drive_idle();
        tick();
        drive_idle();
        tick();
        for (int i = 0; i < 16; i++) begin
            chk++; if (o_mem[i] !== e_mem[i]) begin
                err++; $display("FAIL rnd_row%0d got %h exp %h", i, o_mem[i], e_mem[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) e_mem[i] = 'x;
        test_reset();
        test_single_a();
        test_same_addr();
        test_contention();
        test_oor();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end

endmodule
